// File: rtl/serial_nibble_loader_pkg.sv
// -----------------------------------------------------------------------------
// serial_nibble_pkg
// Shared definitions for the serial-to-parallel nibble loader:
//   WIDTH_DEFAULT : default number of bits per assembled word
//   CNT_W         : bit-position counter width for the default word size
//   word_t        : word type at the default width
//   state_e       : loader state (COLLECT = assembling, HOLD = word pending)
// -----------------------------------------------------------------------------
package serial_nibble_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/serial_nibble_loader_if.sv
// -----------------------------------------------------------------------------
// serial_nibble_loader_if
// Serial input handshake plus parallel word output handshake.
//   ser_in/ser_valid/ser_ready    : one bit per accepted cycle into the loader
//   word_out/word_valid/word_ready: assembled word towards the consumer
// Modports:
//   slave  : the loader side
//   master : the environment side (bit source and word consumer)
// -----------------------------------------------------------------------------
interface serial_nibble_loader_if #(
  parameter int WIDTH = serial_nibble_pkg::WIDTH_DEFAULT
);

  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport slave (
    input  ser_in,
    input  ser_valid,
    input  word_ready,
    output ser_ready,
    output word_out,
    output word_valid
  );

  modport master (
    output ser_in,
    output ser_valid,
    output word_ready,
    input  ser_ready,
    input  word_out,
    input  word_valid
  );

endinterface

// File: rtl/serial_nibble_loader_bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Modulo-WIDTH counter tracking the bit position within the word being built.
//   clk    : clock
//   reset  : asynchronous active-low reset
//   en_i   : advance by one (wraps to 0 after WIDTH-1)
//   clr_i  : synchronous clear, takes priority over en_i
//   cnt_o  : current count
//   tc_o   : count is WIDTH-1 (next enabled cycle completes the word)
// -----------------------------------------------------------------------------
module bit_counter
  import serial_nibble_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/serial_nibble_loader.sv
// -----------------------------------------------------------------------------
// serial_nibble_loader
// Assembles a one-bit-per-cycle serial stream into WIDTH-bit words and offers
// each word on a valid/ready output. A single pending slot (the shift register
// itself, in HOLD) lets one finished word wait while the output is occupied.
//   clk    : clock
//   reset  : asynchronous active-low reset
//   flush  : synchronous clear of partial and pending data (word_out kept)
//   bus    : serial input and word output handshakes (slave modport)
// Parameters:
//   WIDTH     : bits per word (>= 2)
//   MSB_FIRST : 1 -> first serial bit lands in bit WIDTH-1, 0 -> in bit 0
// -----------------------------------------------------------------------------
module serial_nibble_loader
  import serial_nibble_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  serial_nibble_loader_if.slave       bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wv_q, wv_d;

  logic [CW-1:0]    cnt;
  logic             tc;
  logic [CW-1:0]    pos;
  logic             accept;
  logic             slot_free;

  // ser_ready depends on state only, so no input-to-output combinational path.
  assign accept    = bus.ser_valid && (state_q == COLLECT) && !flush;
  assign slot_free = !wv_q || bus.word_ready;
  assign pos       = MSB_FIRST ? (CW'(WIDTH - 1) - cnt) : cnt;

  bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (accept),
    .clr_i (flush),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  // Bits are written by position rather than shifted, so a stale word left in
  // sr after a flush is simply overwritten by the next WIDTH accepts.
  always_comb begin
    sr_d = sr_q;
    if (accept) begin
      sr_d[pos] = bus.ser_in;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wv_d    = wv_q;
    if (flush) begin
      state_d = COLLECT;
      wv_d    = 1'b0;
    end else begin
      if (wv_q && bus.word_ready) begin
        wv_d = 1'b0;
      end
      case (state_q)
        COLLECT: begin
          if (accept && tc) begin
            if (slot_free) begin
              word_d = sr_d;
              wv_d   = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            word_d  = sr_q;
            wv_d    = 1'b1;
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
    end
  end

  assign bus.ser_ready  = (state_q == COLLECT);
  assign bus.word_out   = word_q;
  assign bus.word_valid = wv_q;

endmodule

// File: tb/tb_serial_nibble_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_nibble_loader
// Drives an MSB-first and an LSB-first loader (WIDTH=4) with identical stimulus.
// Directed vector table, hand-written corner sequences, then randomized traffic
// against a bit-queue reference model.
// -----------------------------------------------------------------------------
module tb_serial_nibble_loader;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic flush;

  serial_nibble_loader_if #(.WIDTH(W)) ifm ();
  serial_nibble_loader_if #(.WIDTH(W)) ifl ();

  serial_nibble_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .bus   (ifm)
  );

  serial_nibble_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .bus   (ifl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drv(input bit fl, input bit sv, input bit si, input bit wr);
    flush          = fl;
    ifm.ser_valid  = sv;
    ifl.ser_valid  = sv;
    ifm.ser_in     = si;
    ifl.ser_in     = si;
    ifm.word_ready = wr;
    ifl.word_ready = wr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit esr, input bit ewv,
                         input logic [3:0] em, input logic [3:0] el);
    chk({tag, "_ser_ready_m"}, 32'(ifm.ser_ready), 32'(esr));
    chk({tag, "_ser_ready_l"}, 32'(ifl.ser_ready), 32'(esr));
    chk({tag, "_word_valid_m"}, 32'(ifm.word_valid), 32'(ewv));
    chk({tag, "_word_valid_l"}, 32'(ifl.word_valid), 32'(ewv));
    chk({tag, "_word_out_m"}, 32'(ifm.word_out), 32'(em));
    chk({tag, "_word_out_l"}, 32'(ifl.word_out), 32'(el));
  endtask

  // Word built from serial bits, first bit at index 0 of the array.
  function automatic logic [3:0] word_msb(input bit b[4]);
    int w = 0;
    for (int i = 0; i < 4; i++) w = w * 2 + int'(b[i]);
    return 4'(w);
  endfunction

  function automatic logic [3:0] word_lsb(input bit b[4]);
    int w = 0;
    for (int i = 0; i < 4; i++) w = w + (int'(b[i]) << i);
    return 4'(w);
  endfunction

  typedef struct {
    bit         fl, sv, si, wr;
    bit         e_sr, e_wv;
    logic [3:0] e_m, e_l;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input bit fl, input bit sv, input bit si, input bit wr,
                   input bit esr, input bit ewv, input logic [3:0] em, input logic [3:0] el);
    vec_t r;
    r.fl = fl; r.sv = sv; r.si = si; r.wr = wr;
    r.e_sr = esr; r.e_wv = ewv; r.e_m = em; r.e_l = el;
    tbl.push_back(r);
  endtask

  // Reference model state
  bit         m_bits[$];
  bit         m_pend;
  bit         m_wv;
  logic [3:0] m_om, m_ol, m_pm, m_pl;

  task automatic model_step(input bit fl, input bit sv, input bit si, input bit wr);
    bit free, took, loaded;
    bit b[4];
    if (fl) begin
      m_bits.delete();
      m_pend = 1'b0;
      m_wv   = 1'b0;
      return;
    end
    free   = !m_wv || wr;
    took   = m_wv && wr;
    loaded = 1'b0;
    if (m_pend) begin
      if (free) begin
        m_om = m_pm; m_ol = m_pl; m_pend = 1'b0; loaded = 1'b1;
      end
    end else if (sv) begin
      m_bits.push_back(si);
      if (m_bits.size() == 4) begin
        for (int i = 0; i < 4; i++) b[i] = m_bits[i];
        m_bits.delete();
        if (free) begin
          m_om = word_msb(b); m_ol = word_lsb(b); loaded = 1'b1;
        end else begin
          m_pm = word_msb(b); m_pl = word_lsb(b); m_pend = 1'b1;
        end
      end
    end
    if (loaded) m_wv = 1'b1;
    else if (took) m_wv = 1'b0;
  endtask

  initial begin
    bit         b[4];
    bit         sv, si, wr, fl;

    // Directed vectors: inputs for one cycle, outputs expected after its edge.
    // MSB-first then LSB-first stream 1,0,1,1 with the consumer ready.
    v(0,1,1,1, 1,0, 4'h0,4'h0);
    v(0,1,0,1, 1,0, 4'h0,4'h0);
    v(0,1,1,1, 1,0, 4'h0,4'h0);
    v(0,1,1,1, 1,1, 4'hB,4'hD);
    v(0,0,0,1, 1,0, 4'hB,4'hD);
    // Consumer stalled: 1,0,1,1 then 0,1,1,0 goes to HOLD.
    v(0,1,1,0, 1,0, 4'hB,4'hD);
    v(0,1,0,0, 1,0, 4'hB,4'hD);
    v(0,1,1,0, 1,0, 4'hB,4'hD);
    v(0,1,1,0, 1,1, 4'hB,4'hD);
    v(0,1,0,0, 1,1, 4'hB,4'hD);
    v(0,1,1,0, 1,1, 4'hB,4'hD);
    v(0,1,1,0, 1,1, 4'hB,4'hD);
    v(0,1,0,0, 0,1, 4'hB,4'hD);
    v(0,1,1,0, 0,1, 4'hB,4'hD);   // bit offered while not ready: dropped
    v(0,0,0,1, 1,1, 4'h6,4'h6);   // pending word moves out, ready returns
    v(0,0,0,1, 1,0, 4'h6,4'h6);
    // Flush after 2 bits, then 0,1,1,1.
    v(0,1,1,1, 1,0, 4'h6,4'h6);
    v(0,1,1,1, 1,0, 4'h6,4'h6);
    v(1,1,0,1, 1,0, 4'h6,4'h6);
    v(0,1,0,1, 1,0, 4'h6,4'h6);
    v(0,1,1,1, 1,0, 4'h6,4'h6);
    v(0,1,1,1, 1,0, 4'h6,4'h6);
    v(0,1,1,1, 1,1, 4'h7,4'hE);
    v(0,0,0,1, 1,0, 4'h7,4'hE);
    // Flush while HOLD with a word on the output: both discarded, word_out kept.
    v(0,1,0,0, 1,0, 4'h7,4'hE);
    v(0,1,0,0, 1,0, 4'h7,4'hE);
    v(0,1,0,0, 1,0, 4'h7,4'hE);
    v(0,1,1,0, 1,1, 4'h1,4'h8);
    v(0,1,1,0, 1,1, 4'h1,4'h8);
    v(0,1,1,0, 1,1, 4'h1,4'h8);
    v(0,1,1,0, 1,1, 4'h1,4'h8);
    v(0,1,1,0, 0,1, 4'h1,4'h8);
    v(1,0,0,0, 1,0, 4'h1,4'h8);
    v(0,0,0,0, 1,0, 4'h1,4'h8);
    v(0,1,1,1, 1,0, 4'h1,4'h8);
    v(0,1,0,1, 1,0, 4'h1,4'h8);
    v(0,1,0,1, 1,0, 4'h1,4'h8);
    v(0,1,0,1, 1,1, 4'h8,4'h1);
    v(0,0,0,1, 1,0, 4'h8,4'h1);

    // Reset state
    drv(0,0,0,0);
    rst_n = 1'b0;
    #12;
    chk_out("reset", 1'b1, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drv(tbl[i].fl, tbl[i].sv, tbl[i].si, tbl[i].wr);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].e_sr, tbl[i].e_wv, tbl[i].e_m, tbl[i].e_l);
    end

    // Sustained throughput: 16 cycles, one word every 4 cycles, no stalls.
    for (int k = 1; k <= 16; k++) begin
      si = 1'($urandom_range(0, 1));
      b[(k - 1) % 4] = si;
      drv(0, 1, si, 1);
      tick();
      chk("stream_ser_ready", 32'(ifm.ser_ready), 32'd1);
      chk("stream_word_valid", 32'(ifm.word_valid), 32'((k % 4) == 0));
      if ((k % 4) == 0) begin
        chk("stream_word_m", 32'(ifm.word_out), 32'(word_msb(b)));
        chk("stream_word_l", 32'(ifl.word_out), 32'(word_lsb(b)));
      end
    end

    // Reset asserted during HOLD acts without a clock edge.
    for (int k = 0; k < 8; k++) begin
      drv(0, 1, 1'(k % 2), 0);
      tick();
    end
    chk("hold_entered_ser_ready", 32'(ifm.ser_ready), 32'd0);
    chk("hold_entered_word_valid", 32'(ifm.word_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b1, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    m_bits.delete();
    m_pend = 1'b0; m_wv = 1'b0;
    m_om = 4'h0; m_ol = 4'h0; m_pm = 4'h0; m_pl = 4'h0;
    for (int n = 0; n < 2000; n++) begin
      sv = ($urandom_range(0, 99) < 70);
      si = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 99) < 55);
      fl = ($urandom_range(0, 99) < 3);
      drv(fl, sv, si, wr);
      #1;
      chk("rand_ser_ready_m", 32'(ifm.ser_ready), 32'(!m_pend));
      chk("rand_ser_ready_l", 32'(ifl.ser_ready), 32'(!m_pend));
      model_step(fl, sv, si, wr);
      tick();
      chk("rand_word_valid_m", 32'(ifm.word_valid), 32'(m_wv));
      chk("rand_word_valid_l", 32'(ifl.word_valid), 32'(m_wv));
      chk("rand_word_out_m", 32'(ifm.word_out), 32'(m_om));
      chk("rand_word_out_l", 32'(ifl.word_out), 32'(m_ol));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
